// File: rtl/irq_ctrl_pkg.sv
// Shared peripheral constants for the machine-level interrupt controller.
// Holds register addresses, trap cause codes and FSM state encodings.
package irq_ctrl_pkg;

    localparam logic [31:0] IRQ_BASE     = 32'h0200_1000;

    localparam logic [31:0] OFF_MSIP     = 32'h0;
    localparam logic [31:0] OFF_EXT_EN   = 32'h4;
    localparam logic [31:0] OFF_EXT_PEND = 32'h8;
    localparam logic [31:0] OFF_CLAIM    = 32'hC;

    localparam logic [31:0] IRQ_MSIP     = IRQ_BASE + OFF_MSIP;
    localparam logic [31:0] IRQ_EXT_EN   = IRQ_BASE + OFF_EXT_EN;
    localparam logic [31:0] IRQ_EXT_PEND = IRQ_BASE + OFF_EXT_PEND;
    localparam logic [31:0] IRQ_CLAIM    = IRQ_BASE + OFF_CLAIM;

    localparam logic [3:0]  CAUSE_MSI    = 4'd3;
    localparam logic [3:0]  CAUSE_MTI    = 4'd7;
    localparam logic [3:0]  CAUSE_MEI    = 4'd11;

    localparam logic [1:0]  ST_IDLE      = 2'd0;
    localparam logic [1:0]  ST_REQ       = 2'd1;
    localparam logic [1:0]  ST_ACTIVE    = 2'd2;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line plus a
// single-cycle rising-edge pulse on the synchronized level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: MSIP, timer and claimable external
// sources merged into one registered request with cause code.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_EXT     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               wready,
    output logic               wvalid,
    input  logic [31:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               rready,
    output logic               rvalid,
    input  logic [31:0]        raddr,
    output logic               rresp,
    output logic [31:0]        rdata,
    input  logic               timer_irq,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               mstatus_mie,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic               mie_meie,
    input  logic               irq_ack,
    input  logic               irq_mret,
    output logic               irq_req,
    output logic [3:0]         irq_cause
);

    logic               r_msip;
    logic [NUM_EXT-1:0] r_en;
    logic [NUM_EXT-1:0] r_pend;
    logic [NUM_EXT-1:0] r_insvc;
    logic [1:0]         r_state;
    logic               r_req;
    logic [3:0]         r_cause;
    logic               r_rresp;
    logic [31:0]        r_rdata;

    logic [NUM_EXT-1:0] w_edge;
    logic [NUM_EXT-1:0] w_elig;
    logic [NUM_EXT-1:0] w_claim_oh;
    logic [NUM_EXT-1:0] w_cmpl_oh;
    logic [NUM_EXT-1:0] w_w1c;
    logic [4:0]         w_claim_id;
    logic               w_wr_msip;
    logic               w_wr_en;
    logic               w_wr_pend;
    logic               w_wr_claim;
    logic               w_rd_claim;
    logic               w_rd_hit;
    logic [31:0]        w_rd_val;
    logic               w_sw;
    logic               w_tm;
    logic               w_ex;
    logic               w_any;
    logic [3:0]         w_win;
    logic               w_unused;

    assign wvalid    = 1'b1;
    assign rvalid    = 1'b1;
    assign w_unused  = ^wstrb;

    assign w_wr_msip  = wready && (waddr == IRQ_MSIP);
    assign w_wr_en    = wready && (waddr == IRQ_EXT_EN);
    assign w_wr_pend  = wready && (waddr == IRQ_EXT_PEND);
    assign w_wr_claim = wready && (waddr == IRQ_CLAIM);
    assign w_rd_claim = rready && (raddr == IRQ_CLAIM);

    for (genvar g = 0; g < NUM_EXT; g++) begin : g_ext
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .resetb  (resetb),
            .i_async (ext_irq[g]),
            .o_rise  (w_edge[g])
        );
    end

    // Lowest eligible line wins the claim; scan downward so it lands last.
    always_comb begin
        w_elig     = r_pend & r_en & ~r_insvc;
        w_claim_id = '0;
        w_claim_oh = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_claim_id    = 5'(i + 1);
                w_claim_oh    = '0;
                w_claim_oh[i] = 1'b1;
            end
        end
        if (!w_rd_claim) begin
            w_claim_oh = '0;
        end
    end

    always_comb begin
        w_cmpl_oh = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            w_cmpl_oh[i] = w_wr_claim && (wdata == 32'(i + 1));
        end
        w_w1c = w_wr_pend ? wdata[NUM_EXT-1:0] : '0;
    end

    always_comb begin
        w_rd_hit = 1'b1;
        w_rd_val = '0;
        case (raddr)
            IRQ_MSIP:     w_rd_val = {31'b0, r_msip};
            IRQ_EXT_EN:   w_rd_val = 32'(r_en);
            IRQ_EXT_PEND: w_rd_val = 32'(r_pend);
            IRQ_CLAIM:    w_rd_val = 32'(w_claim_id);
            default:      w_rd_hit = 1'b0;
        endcase
    end

    assign w_sw  = r_msip & mie_msie;
    assign w_tm  = timer_irq & mie_mtie;
    assign w_ex  = (|w_elig) & mie_meie;
    assign w_any = mstatus_mie & (w_sw | w_tm | w_ex);
    assign w_win = w_ex ? CAUSE_MEI : (w_sw ? CAUSE_MSI : CAUSE_MTI);

    // A fresh edge overrides a same-cycle W1C or claim on that bit.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_msip  <= 1'b0;
            r_en    <= '0;
            r_pend  <= '0;
            r_insvc <= '0;
            r_rresp <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_wr_msip) r_msip <= wdata[0];
            if (w_wr_en)   r_en   <= wdata[NUM_EXT-1:0];
            r_pend  <= (r_pend & ~w_w1c & ~w_claim_oh) | w_edge;
            r_insvc <= (r_insvc & ~w_cmpl_oh) | w_claim_oh;
            r_rresp <= rready;
            if (rready && w_rd_hit) r_rdata <= w_rd_val;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_cause <= w_win;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        r_state <= ST_ACTIVE;
                        r_req   <= 1'b0;
                    end else if (!w_any) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (irq_mret) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign rresp     = r_rresp;
    assign rdata     = r_rdata;
    assign irq_req   = r_req;
    assign irq_cause = r_cause;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-level interrupt controller downstream of the memory-mapped timer; consumes timer_irq, a software-interrupt register and NUM_EXT asynchronous external lines.
- Presents one registered interrupt request plus cause code to the core trap logic, using a request/acknowledge/return handshake.
- Memory-mapped on the same always-ready peripheral bus as the timer.

Parameters:
- NUM_EXT, 4, number of external interrupt lines (1..31).
- SYNC_STAGES, 2, synchronizer flops per external line (>=2).

Ports:
- clk  input  1  clock
- resetb  input  1  reset, asynchronous, active-low
- wready  input  1  write strobe
- wvalid  output  1  tied 1
- waddr  input  32  write address
- wdata  input  32  write data
- wstrb  input  4  ignored; full-word writes
- rready  input  1  read strobe
- rvalid  output  1  tied 1
- raddr  input  32  read address
- rresp  output  1  read response, 1 cycle after rready
- rdata  output  32  registered read data
- timer_irq  input  1  level from timer
- ext_irq  input  NUM_EXT  asynchronous, rising-edge-triggered
- mstatus_mie  input  1  global enable
- mie_msie, mie_mtie, mie_meie  input  1 each  per-class enables
- irq_ack  input  1  one-cycle pulse: core entered trap
- irq_mret  input  1  one-cycle pulse: core executed mret
- irq_req  output  1  interrupt request
- irq_cause  output  4  3 = software, 7 = timer, 11 = external

Behaviour:
- Register map (offsets from IRQ_BASE):
  - +0x0 MSIP: bit0 R/W.
  - +0x4 EXT_EN: R/W, NUM_EXT bits.
  - +0x8 EXT_PEND: read; write-1-to-clear.
  - +0xC CLAIM: read claims; write completes.
  - Unused bits read 0.
- Read timing: rresp <= rready each cycle. rdata loads only on rready with a mapped address; an unmapped address holds rdata.
- External path:
  - ext_irq passes through SYNC_STAGES flops, then a rising-edge detector sets pend[i].
  - Same-cycle edge and W1C, or edge and claim, on one bit: the edge wins and pend stays 1.
- Claim read:
  - Returns id = lowest i with pend & en & ~insvc, plus 1; returns 0 if none.
  - For a nonzero id, clears pend[id-1] and sets insvc[id-1] in the same cycle as rready.
  - Returning 0 has no effect.
- Complete: writing id (1..NUM_EXT) to CLAIM clears insvc[id-1]. Out-of-range ids are ignored.
- Source levels:
  - ext_lvl = |(pend & en & ~insvc)
  - sw = MSIP & mie_msie
  - tm = timer_irq & mie_mtie
  - ex = ext_lvl & mie_meie
  - any = mstatus_mie & (sw | tm | ex)
  - Priority: ex > sw > tm.
- FSM:
  - IDLE: if any, go to REQ. On entry, irq_req <= 1 and irq_cause <= winner (1-cycle latency from source to irq_req).
  - REQ:
    - irq_ack -> ACTIVE, irq_req <= 0.
    - Else if !any -> IDLE, irq_req <= 0.
    - irq_ack wins over a simultaneous source drop.
    - irq_cause is frozen while in REQ.
  - ACTIVE: irq_req held 0. irq_mret -> IDLE. irq_mret in IDLE or REQ is ignored.
  - irq_ack outside REQ is ignored.
- Reset values:
  - irq_req 0, irq_cause 0, rresp 0, rdata 0, state IDLE.
  - MSIP, EXT_EN, pend, insvc and synchronizers all 0.
  - The async reset is honoured mid-handshake; the core must treat a reset-dropped irq_req as no request.

Decomposition:
- Shared constants file alongside the existing peripheral bases: IRQ_BASE, offsets MSIP/EXT_EN/EXT_PEND/CLAIM, cause codes CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11, and the FSM state encodings.
- One sub-module, irq_sync_edge: a SYNC_STAGES synchronizer plus rising-edge pulse, instantiated NUM_EXT times via generate.

Test Plan:
- MSIP path: mstatus_mie=1, mie_msie=1, write 1 to MSIP -> irq_req=1 with cause 3 one cycle later. Pulse irq_ack -> irq_req=0. Pulse irq_mret while MSIP still 1 -> irq_req=1 again.
- Priority: timer_irq=1 and ext_irq[2] rising with EXT_EN=0x4, all enables 1 -> cause 11. Claim read returns 3, EXT_PEND reads 0. Write 3 to CLAIM, then mret -> cause 7.
- Claim ordering: edges on ext[0] and ext[3], EXT_EN=0x9 -> claims return 1, then 4, then 0. A new ext[0] edge before completing id 1 -> pend[0]=1 but not offered until completion.
- Retraction: cause 7 in REQ, timer_irq falls without ack -> IDLE, irq_req=0. Repeat with irq_ack in the same cycle as the fall -> ACTIVE.
- Collision: W1C of pend[1] in the same cycle as a synchronized ext[1] edge -> EXT_PEND bit1 reads 1. Unmapped read -> rresp=1, rdata unchanged.
- Reset: assert resetb=0 while in REQ -> irq_req=0 immediately. All registers read 0 afterwards.
